dc_hex_word_asm: RTL and testbench



---
 rtl/dc_hex_word_asm_pkg.sv | 14 +
 rtl/dc_hex_word_asm_ascii_hex.sv | 15 +
 rtl/dc_hex_word_asm.sv | 91 +++++++++
 tb/tb_dc_hex_word_asm.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_hex_word_asm_pkg.sv
// dc_hex_word_asm_pkg: shared constants and state encoding for the hex word assembler.
package dc_hex_word_asm_pkg;
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_BADCHAR = 2'b01;
  localparam logic [1:0] ERR_OVF     = 2'b10;
  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_XL = 8'h78;
  localparam logic [7:0] CHR_XU = 8'h58;
  typedef enum logic [1:0] {COLLECT = 2'd0, SKIP = 2'd1, HOLD = 2'd2} state_t;
  function automatic logic is_term(input logic [7:0] c);
    return c == CHR_CR || c == CHR_LF;
  endfunction
endpackage

// File: rtl/dc_hex_word_asm_ascii_hex.sv
// dc_ascii_hex: combinational ASCII to hex nibble converter with digit-valid flag.
module dc_ascii_hex (
  input  logic [7:0] ASCII,
  output logic [3:0] HEX,
  output logic       HEX_FLG
);
  logic dig, alp;
  always_comb begin
    dig = ASCII >= 8'h30 && ASCII <= 8'h39;
    // folding to lower case maps 'A'-'F' onto 'a'-'f'
    alp = (ASCII | 8'h20) >= 8'h61 && (ASCII | 8'h20) <= 8'h66;
    HEX_FLG = dig | alp;
    HEX = dig ? ASCII[3:0] : alp ? ASCII[3:0] + 4'd9 : 4'h0;
  end
endmodule

// File: rtl/dc_hex_word_asm.sv
// dc_hex_word_asm: assembles hex characters MSB-first into a word, terminated by CR/LF.
// Optional "0x"/"0X" prefix acceptance enabled by defining DC_HEX_WORD_ASM_PREFIX_EN.
module dc_hex_word_asm
  import dc_hex_word_asm_pkg::*;
#(
  parameter int WORD_NIBBLES = 8
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic [7:0]                        ASCII_IN,
  input  logic                              ASCII_VLD,
  output logic                              ASCII_RDY,
  output logic [4*WORD_NIBBLES-1:0]         DATA,
  output logic [$clog2(WORD_NIBBLES+1)-1:0] NIB_CNT,
  output logic                              DATA_VLD,
  input  logic                              DATA_RDY,
  output logic                              ERR,
  output logic [1:0]                        ERR_CODE
);
  localparam int CW = $clog2(WORD_NIBBLES+1);
  state_t state, state_n;
  logic [4*WORD_NIBBLES-1:0] acc, acc_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] nib;
  logic is_hex, take, term, full, err_n, pfx, pfx_n, pfx_ok;
  logic [1:0] code_n;
  dc_ascii_hex u_conv (.ASCII(ASCII_IN), .HEX(nib), .HEX_FLG(is_hex));
  assign ASCII_RDY = state != HOLD;
  assign DATA_VLD = state == HOLD;
  assign DATA = acc;
  assign NIB_CNT = cnt;
  assign take = ASCII_VLD & ASCII_RDY;
  assign term = is_term(ASCII_IN);
  assign full = cnt == CW'(WORD_NIBBLES);
`ifdef DC_HEX_WORD_ASM_PREFIX_EN
  // prefix is legal only right after a lone leading '0'
  assign pfx_ok = (ASCII_IN == CHR_XL || ASCII_IN == CHR_XU) && cnt == CW'(1) && acc == '0 && !pfx;
`else
  assign pfx_ok = 1'b0;
`endif
  always_comb begin
    state_n = state;
    acc_n = acc;
    cnt_n = cnt;
    pfx_n = pfx;
    err_n = 1'b0;
    code_n = ERR_NONE;
    if ((state == HOLD && DATA_RDY) || (state == SKIP && take && term)) begin
      state_n = COLLECT;
      acc_n = '0;
      cnt_n = '0;
      pfx_n = 1'b0;
    end else if (state == COLLECT && take) begin
      if (is_hex && full) begin
        state_n = SKIP;
        err_n = 1'b1;
        code_n = ERR_OVF;
      end else if (is_hex) begin
        acc_n = {acc[4*WORD_NIBBLES-5:0], nib};
        cnt_n = cnt + CW'(1);
      end else if (term) begin
        state_n = cnt != '0 ? HOLD : COLLECT;
        pfx_n = 1'b0;
      end else if (pfx_ok) begin
        cnt_n = '0;
        pfx_n = 1'b1;
      end else begin
        state_n = SKIP;
        err_n = 1'b1;
        code_n = ERR_BADCHAR;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= COLLECT;
      acc <= '0;
      cnt <= '0;
      pfx <= 1'b0;
      ERR <= 1'b0;
      ERR_CODE <= ERR_NONE;
    end else begin
      state <= state_n;
      acc <= acc_n;
      cnt <= cnt_n;
      pfx <= pfx_n;
      ERR <= err_n;
      ERR_CODE <= code_n;
    end
  end
endmodule

// File: tb/tb_dc_hex_word_asm.sv
// tb_dc_hex_word_asm: directed and randomized checks against a character-level reference model.
module tb_dc_hex_word_asm;
  localparam int N = 8;
`ifdef DC_HEX_WORD_ASM_PREFIX_EN
  localparam bit PFX = 1'b1;
`else
  localparam bit PFX = 1'b0;
`endif
  logic CLK = 1'b0, RST_N = 1'b0, ASCII_VLD = 1'b0, DATA_RDY = 1'b1;
  logic [7:0] ASCII_IN = 8'h00;
  logic ASCII_RDY, DATA_VLD, ERR;
  logic [31:0] DATA;
  logic [3:0] NIB_CNT;
  logic [1:0] ERR_CODE;
  int compared = 0, mismatched = 0;
  bit rand_rdy = 0;
  logic [39:0] exp_w[$], got_w[$];
  logic [1:0] exp_e[$], got_e[$];
  int m_n = 0;
  longint m_v = 0;
  bit m_skip = 0, m_pfx = 0;
  logic [31:0] pd = '0;
  logic pv = 1'b0, pr = 1'b0, pn = 1'b0;

  dc_hex_word_asm #(.WORD_NIBBLES(N)) dut (
    .CLK(CLK), .RST_N(RST_N), .ASCII_IN(ASCII_IN), .ASCII_VLD(ASCII_VLD), .ASCII_RDY(ASCII_RDY),
    .DATA(DATA), .NIB_CNT(NIB_CNT), .DATA_VLD(DATA_VLD), .DATA_RDY(DATA_RDY),
    .ERR(ERR), .ERR_CODE(ERR_CODE)
  );

  always #5 CLK = ~CLK;

  // monitor: records transfers and error pulses, checks that a held word stays put
  always @(negedge CLK) begin
    if (RST_N && pn && pv && !pr) begin
      compared++;
      if (DATA_VLD !== 1'b1 || DATA !== pd) begin
        mismatched++;
        $display("FAIL hold_stable: vld=%b data=%h required vld=1 data=%h", DATA_VLD, DATA, pd);
      end
    end
    if (RST_N) begin
      if (DATA_VLD && DATA_RDY) got_w.push_back({4'b0, NIB_CNT, DATA});
      if (ERR) got_e.push_back(ERR_CODE);
    end
    pv = DATA_VLD; pr = DATA_RDY; pd = DATA; pn = RST_N;
  end

  function automatic int hexval(input logic [7:0] c);
    if (c >= 8'd48 && c <= 8'd57) return int'(c) - 48;
    if (c >= 8'd65 && c <= 8'd70) return int'(c) - 55;
    if (c >= 8'd97 && c <= 8'd102) return int'(c) - 87;
    return -1;
  endfunction

  function automatic void model_reset();
    m_n = 0; m_v = 0; m_skip = 0; m_pfx = 0;
  endfunction

  function automatic void model(input logic [7:0] c);
    int d = hexval(c);
    bit t = (c == 8'h0D || c == 8'h0A);
    if (m_skip) begin
      if (t) model_reset();
    end else if (d >= 0) begin
      if (m_n == N) begin exp_e.push_back(2'b10); m_skip = 1; end
      else begin m_v = m_v * 16 + longint'(d); m_n++; end
    end else if (t) begin
      if (m_n > 0) exp_w.push_back({8'(m_n), 32'(m_v)});
      model_reset();
    end else if (PFX && (c == 8'h78 || c == 8'h58) && m_n == 1 && m_v == 0 && !m_pfx) begin
      m_n = 0; m_pfx = 1;
    end else begin
      exp_e.push_back(2'b01); m_skip = 1;
    end
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
    if (rand_rdy) DATA_RDY = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_char(input logic [7:0] c);
    bit ok = 0;
    ASCII_IN = c;
    ASCII_VLD = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      ok = ASCII_RDY;
      tick();
    end
    ASCII_VLD = 1'b0;
    if (ok) model(c);
    else begin
      compared++; mismatched++;
      $display("FAIL send_timeout: char %h never accepted, required acceptance within 200 cycles", c);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_char(s[i]);
      if (rand_rdy) repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic check_q(input string name);
    rand_rdy = 0;
    DATA_RDY = 1'b1;
    repeat (4) tick();
    compared++;
    if (got_w.size() != exp_w.size()) begin
      mismatched++;
      $display("FAIL %s word_count: got %0d required %0d", name, got_w.size(), exp_w.size());
    end else foreach (exp_w[i]) begin
      compared++;
      if (got_w[i] !== exp_w[i]) begin
        mismatched++;
        $display("FAIL %s word[%0d]: got cnt/data %h required %h", name, i, got_w[i], exp_w[i]);
      end
    end
    compared++;
    if (got_e.size() != exp_e.size()) begin
      mismatched++;
      $display("FAIL %s err_count: got %0d required %0d", name, got_e.size(), exp_e.size());
    end else foreach (exp_e[i]) begin
      compared++;
      if (got_e[i] !== exp_e[i]) begin
        mismatched++;
        $display("FAIL %s err_code[%0d]: got %b required %b", name, i, got_e[i], exp_e[i]);
      end
    end
    exp_w.delete(); got_w.delete(); exp_e.delete(); got_e.delete();
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    tick(); tick();
    compared += 6;
    if (ASCII_RDY !== 1'b1) begin mismatched++; $display("FAIL reset_rdy: got %b required 1", ASCII_RDY); end
    if (DATA_VLD !== 1'b0) begin mismatched++; $display("FAIL reset_vld: got %b required 0", DATA_VLD); end
    if (ERR !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b required 0", ERR); end
    if (ERR_CODE !== 2'b00) begin mismatched++; $display("FAIL reset_code: got %b required 00", ERR_CODE); end
    if (NIB_CNT !== 4'd0) begin mismatched++; $display("FAIL reset_cnt: got %0d required 0", NIB_CNT); end
    if (DATA !== 32'h0) begin mismatched++; $display("FAIL reset_data: got %h required 0", DATA); end
    RST_N = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic test_basic();
    DATA_RDY = 1'b1;
    send_str("1A2b");
    send_char(8'h0D);
    compared++;
    if (DATA_VLD !== 1'b1 || DATA !== 32'h1A2B || NIB_CNT !== 4'd4) begin
      mismatched++;
      $display("FAIL basic_latency: vld=%b data=%h cnt=%0d required 1 00001a2b 4", DATA_VLD, DATA, NIB_CNT);
    end
    check_q("basic");
  endtask

  task automatic test_empty();
    logic [7:0] seq [4] = '{8'h0D, 8'h0A, 8'h0D, 8'h0A};
    foreach (seq[i]) begin
      send_char(seq[i]);
      compared++;
      if (ASCII_RDY !== 1'b1 || DATA_VLD !== 1'b0) begin
        mismatched++;
        $display("FAIL empty_line[%0d]: rdy=%b vld=%b required 1 0", i, ASCII_RDY, DATA_VLD);
      end
    end
    check_q("empty");
  endtask

  task automatic test_badchar();
    send_str("12");
    send_char("G");
    compared++;
    if (ERR !== 1'b1 || ERR_CODE !== 2'b01) begin
      mismatched++;
      $display("FAIL badchar_pulse: err=%b code=%b required 1 01", ERR, ERR_CODE);
    end
    send_str("4\r5\n");
    check_q("badchar");
  endtask

  task automatic test_overflow();
    send_str("12345678");
    send_char("9");
    compared++;
    if (ERR !== 1'b1 || ERR_CODE !== 2'b10) begin
      mismatched++;
      $display("FAIL overflow_pulse: err=%b code=%b required 1 10", ERR, ERR_CODE);
    end
    send_str("\r");
    compared++;
    if (DATA_VLD !== 1'b0) begin mismatched++; $display("FAIL overflow_novld: got %b required 0", DATA_VLD); end
    send_str("ABCDEF01\n");
    check_q("overflow");
  endtask

  task automatic test_back_to_back();
    DATA_RDY = 1'b0;
    send_str("FF\r");
    ASCII_IN = "7";
    ASCII_VLD = 1'b1;
    for (int i = 0; i < 5; i++) begin
      compared++;
      if (DATA_VLD !== 1'b1 || DATA !== 32'hFF || ASCII_RDY !== 1'b0 || NIB_CNT !== 4'd2) begin
        mismatched++;
        $display("FAIL backpressure[%0d]: vld=%b data=%h rdy=%b cnt=%0d required 1 000000ff 0 2", i, DATA_VLD, DATA, ASCII_RDY, NIB_CNT);
      end
      tick();
    end
    DATA_RDY = 1'b1;
    send_char("7");
    send_char(8'h0D);
    check_q("back_to_back");
  endtask

  task automatic test_reset_mid();
    send_str("AB");
    RST_N = 1'b0; tick(); RST_N = 1'b1;
    model_reset();
    compared++;
    if (NIB_CNT !== 4'd0 || DATA !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_partial: cnt=%0d data=%h required 0 0", NIB_CNT, DATA);
    end
    send_str("C\r");
    check_q("reset_mid");
    DATA_RDY = 1'b0;
    send_str("5\r");
    RST_N = 1'b0; tick(); RST_N = 1'b1;
    model_reset();
    void'(exp_w.pop_back());
    compared++;
    if (DATA_VLD !== 1'b0 || ASCII_RDY !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_pending: vld=%b rdy=%b required 0 1", DATA_VLD, ASCII_RDY);
    end
    check_q("reset_pending");
  endtask

  task automatic test_prefix();
    send_str("0x1f\r");
    check_q("prefix");
    send_str("0X\r0x0x1\r10x\r");
    check_q("prefix_misuse");
  endtask

  task automatic test_random();
    string pool = "0123456789abcdefABCDEF\r\n\r\n\r\nxXG 0";
    rand_rdy = 1;
    for (int i = 0; i < 500; i++) begin
      send_char(pool[$urandom_range(0, pool.len() - 1)]);
      repeat ($urandom_range(0, 2)) tick();
    end
    check_q("random");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_badchar();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_prefix();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
